// File: rtl/mealy_pattern_pkg.sv
// Purpose : shared types and output codes for the run-parity classifier.
// Latency : n/a (package only).
// Backpressure: n/a.
package mealy_pattern_pkg;

    // One flop is enough: only the parity of the current run of 1s matters.
    typedef enum logic {
        S_EVEN = 1'b0,  // run of 1s so far has even length (including zero)
        S_ODD  = 1'b1   // run of 1s so far has odd length
    } state_t;

    localparam logic [1:0] O_NONE = 2'b00;  // current bit is 0
    localparam logic [1:0] O_ODD  = 2'b10;  // current 1 closes an odd-length run
    localparam logic [1:0] O_EVEN = 2'b01;  // current 1 closes an even-length run

endpackage : mealy_pattern_pkg

// File: rtl/mealy_pattern.sv
// Purpose : Mealy run-parity detector; classifies each serial bit by the parity
//           of the current run of consecutive 1s, including the present bit.
// Latency : o is combinational from state and i (same cycle); state updates on
//           the rising edge of clock.
// Backpressure: none; one bit accepted every cycle.
//
// Ports:
//   clock   - system clock, state updates on rising edge
//   reset_n - asynchronous active-low reset, forces S_EVEN and o = 00
//   i       - serial data bit
//   o       - 2'b10 odd-length run, 2'b01 even-length run, 2'b00 on a 0 bit
module mealy_pattern
    import mealy_pattern_pkg::*;
(
    input  logic       clock,
    input  logic       reset_n,
    input  logic       i,
    output logic [1:0] o
);

    state_t     r_state;
    state_t     w_next_state;
    logic [1:0] w_out;

    // State register: reset clears any partially seen run.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_EVEN;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state / Mealy output. Any 0 ends the run, so every i=0 path
    // returns to S_EVEN with no classification.
    always_comb begin
        w_next_state = S_EVEN;
        w_out        = O_NONE;
        case (r_state)
            S_EVEN: begin
                if (i) begin
                    w_out        = O_ODD;
                    w_next_state = S_ODD;
                end
            end
            S_ODD: begin
                if (i) begin
                    w_out        = O_EVEN;
                    w_next_state = S_EVEN;
                end
            end
            default: begin
                w_out        = O_NONE;
                w_next_state = S_EVEN;
            end
        endcase
    end

    // While reset is held the state is already S_EVEN, which would otherwise
    // report 10 for i=1; the output is forced quiet until release.
    assign o = reset_n ? w_out : O_NONE;

endmodule : mealy_pattern

// File: tb/tb_mealy_pattern.sv
// Purpose : self-checking bench for mealy_pattern against a run-length model.
// Latency : checks o combinationally, mid-cycle after each input change.
// Backpressure: n/a.
module tb_mealy_pattern;

    logic       clock;
    logic       reset_n;
    logic       i;
    logic [1:0] o;

    int total = 0;
    int bad   = 0;
    int run_len = 0;   // reference: length of current run of 1s already clocked in

    mealy_pattern dut (
        .clock   (clock),
        .reset_n (reset_n),
        .i       (i),
        .o       (o)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference classification: length the run would have including this bit.
    function automatic logic [1:0] model_o(input int run, input logic b, input logic rn);
        if (!rn || !b) return 2'b00;
        return (((run + 1) % 2) == 1) ? 2'b10 : 2'b01;
    endfunction

    task automatic check(input string tag, input logic [1:0] exp);
        total++;
        assert (o === exp)
        else begin
            bad++;
            $error("FAIL %s: o=%b expected=%b", tag, o, exp);
        end
    endtask

    // Drive one bit in the low phase, check o, then account for the next edge.
    task automatic step(input logic b, input string tag);
        @(negedge clock);
        i = b;
        #1;
        check(tag, model_o(run_len, b, reset_n));
        run_len = (reset_n && b) ? run_len + 1 : 0;
    endtask

    task automatic seq(input logic [15:0] bits, input int n, input string tag);
        for (int k = n - 1; k >= 0; k--) begin
            step(bits[k], $sformatf("%s[%0d]", tag, n - 1 - k));
        end
    endtask

    // Async reset pulse placed entirely between edges, with i held at 1.
    task automatic reset_pulse(input string tag);
        @(negedge clock);
        i       = 1'b1;
        reset_n = 1'b0;
        #1;
        check({tag, "_during"}, 2'b00);
        run_len = 0;
        #1;
        reset_n = 1'b1;
        #1;
        check({tag, "_after"}, model_o(run_len, 1'b1, reset_n));
        run_len = run_len + 1;
    endtask

    initial begin
        logic b;

        // Reset held with i=1: output quiet.
        reset_n = 1'b0;
        i       = 1'b1;
        #3;
        check("reset_hold", 2'b00);
        @(negedge clock);
        #1;
        check("reset_hold_edge", 2'b00);
        // Release between edges; first 1 must read as run length 1.
        reset_n = 1'b1;
        #1;
        check("release_first1", 2'b10);
        run_len = 1;
        step(1'b0, "clr");

        // Reference sequence 1,1,1,0,0,1,1,0,0,1.
        seq(16'b1110011001, 10, "ref");
        step(1'b0, "ref_end");

        // Long run of 7 ones then a 0.
        seq(16'b11111110, 8, "long");

        // Isolated ones.
        seq(16'b10101, 5, "iso");
        step(1'b0, "iso_end");

        // Reset mid-run after two ones, and after one one (state odd).
        seq(16'b11, 2, "mid2");
        reset_pulse("rst2");
        step(1'b0, "rst2_end");
        seq(16'b1, 1, "mid1");
        reset_pulse("rst1");
        step(1'b1, "rst1_next");
        step(1'b0, "rst1_end");

        // Glitch on i within a cycle while in S_ODD; final value 0 decides state.
        step(1'b1, "gl_setup");
        @(negedge clock);
        i = 1'b0;
        #1;
        check("gl_0", 2'b00);
        i = 1'b1;
        #1;
        check("gl_1", 2'b01);
        i = 1'b0;
        #1;
        check("gl_0b", 2'b00);
        run_len = 0;
        step(1'b1, "gl_next");

        // Randomized stream, biased toward runs, with occasional reset pulses.
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 24) == 0) begin
                reset_pulse($sformatf("rnd_rst%0d", n));
            end else begin
                b = ($urandom_range(0, 3) != 0);
                step(b, $sformatf("rnd%0d", n));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_mealy_pattern
